// File: rtl/deco_7seg_with_mux_reg_pkg.sv
// Shared types and the hex glyph table for the 7-segment decoder.
// Patterns are stored active-low in {dp,g,f,e,d,c,b,a} order. The dp bit is
// always 1, so the decimal point stays dark.
package deco_7seg_pkg;

   typedef logic [7:0] seg_t;

   // All segments dark when the display is driven active-low.
   localparam seg_t SEG_BLANK = 8'hFF;

   // Glyphs 0-9, A, b, C, d, E, F.
   // The letters b and d are lowercase shapes.
   localparam seg_t HEX_LUT [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0,
      8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83,
      8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Returns the blank pattern in the output polarity selected by the
   // active_low argument.
   function automatic seg_t blank_pattern(input bit active_low);
      return active_low ? SEG_BLANK : ~SEG_BLANK;
   endfunction

endpackage

// File: rtl/deco_7seg_with_mux_reg_if.sv
// Nibble-to-glyph link between the select mux and the decoder.
// There is no valid/ready handshake on this link. The nibble is a level
// signal, and seg follows it combinationally every cycle.
interface deco_7seg_with_mux_reg_if;
   import deco_7seg_pkg::*;

   logic [3:0] nibble;
   seg_t       seg;

   modport master (output nibble, input seg);
   modport slave  (input nibble, output seg);
endinterface

// File: rtl/deco_7seg_with_mux_reg_hex_to_7seg.sv
// Combinational hex-digit decoder.
// Output polarity is set here, so the register downstream loads a
// ready-to-drive pattern.
module hex_to_7seg
   import deco_7seg_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   deco_7seg_with_mux_reg_if.slave dec
);

   seg_t seg_raw;

   // Look up the active-low glyph, then flip every bit for common-cathode use.
   always_comb begin
      seg_raw = HEX_LUT[dec.nibble];
      dec.seg = SEG_ACTIVE_LOW ? seg_raw : ~seg_raw;
   end

endmodule

// File: rtl/deco_7seg_with_mux_reg.sv
// Switch-nibble selector and registered 7-segment driver.
// The btn code selects one of four switch nibbles. The selected nibble is
// decoded into a hex glyph, and the glyph is registered one clock later.
module deco_7seg_with_mux_reg
   import deco_7seg_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] sw_1_4,
   input  logic [3:0] sw_5_8,
   input  logic [3:0] sw_9_12,
   input  logic [3:0] sw_13_16,
   input  logic [1:0] btn,
   output logic [7:0] segments
);

   localparam seg_t RST_VAL = blank_pattern(SEG_ACTIVE_LOW);

   deco_7seg_with_mux_reg_if dec_if ();

   logic [3:0] nibble_sel;
   seg_t       segments_d;
   seg_t       segments_q;

   // 4:1 nibble select. Every btn code is legal.
   always_comb begin
      nibble_sel = sw_1_4;
      case (btn)
         2'b00: nibble_sel = sw_1_4;
         2'b01: nibble_sel = sw_5_8;
         2'b10: nibble_sel = sw_9_12;
         2'b11: nibble_sel = sw_13_16;
      endcase
   end

   assign dec_if.nibble = nibble_sel;

   hex_to_7seg #(
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
   ) u_hex_to_7seg (
      .dec (dec_if.slave)
   );

   // Next display pattern, taken straight from the decoder.
   always_comb begin
      segments_d = dec_if.seg;
   end

   // Output register. Synchronous reset blanks the digit and takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         segments_q <= RST_VAL;
      end else begin
         segments_q <= segments_d;
      end
   end

   assign segments = segments_q;

endmodule

// File: tb/tb_deco_7seg_with_mux_reg.sv
// Bench for deco_7seg_with_mux_reg with the default active-low polarity.
module tb_deco_7seg_with_mux_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw [4];
   logic [1:0] btn;
   logic [7:0] segments;

   int n_cmp = 0;
   int n_err = 0;

   // Glyph table written out from the display chart, active-low {dp,g..a}.
   logic [7:0] glyph [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   // Carries the nibble the bench believes is selected, shown in reports.
   deco_7seg_with_mux_reg_if tb_if ();

   always #5 clk = ~clk;

   deco_7seg_with_mux_reg dut (
      .clk      (clk),
      .rst      (rst),
      .sw_1_4   (sw[0]),
      .sw_5_8   (sw[1]),
      .sw_9_12  (sw[2]),
      .sw_13_16 (sw[3]),
      .btn      (btn),
      .segments (segments)
   );

   assign tb_if.nibble = sw[btn];
   assign tb_if.seg    = segments;

   // Reference model: the value the display must show after the next edge.
   function automatic logic [7:0] model_next();
      if (rst) return 8'hFF;
      return glyph[sw[btn]];
   endfunction

   task automatic check(input string tag, input logic [7:0] exp);
      n_cmp++;
      assert (segments === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h (nibble=%h btn=%0d)",
                tag, segments, exp, tb_if.nibble, btn);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] exp;

   initial begin
      rst = 1'b1;
      btn = 2'($urandom_range(0, 3));
      for (int i = 0; i < 4; i++) sw[i] = 4'($urandom_range(0, 15));

      // Reset held for two edges
      tick(); check("reset_1", 8'hFF);
      btn = 2'($urandom_range(0, 3));
      tick(); check("reset_2", 8'hFF);

      // Release reset showing 0
      rst = 1'b0; btn = 2'b00; sw[0] = 4'd0;
      tick(); check("post_reset_0", 8'hC0);

      // Select 0, then disturb the unselected nibbles
      sw[0] = 4'd10;
      tick(); check("sel0_A", 8'h88);
      for (int k = 0; k < 3; k++) begin
         sw[1] = 4'($urandom_range(0, 15));
         sw[2] = 4'($urandom_range(0, 15));
         sw[3] = 4'($urandom_range(0, 15));
         tick(); check("sel0_hold", 8'h88);
      end

      btn = 2'b01; sw[1] = 4'd7;
      tick(); check("sel1_7", 8'hF8);
      btn = 2'b10; sw[2] = 4'd15;
      tick(); check("sel2_F", 8'h8E);
      btn = 2'b11; sw[3] = 4'd2;
      tick(); check("sel3_2", 8'hA4);

      // Full table sweep on every select code
      for (int b = 0; b < 4; b++) begin
         for (int v = 0; v < 16; v++) begin
            btn = 2'(b);
            sw[b] = 4'(v);
            exp = model_next();
            tick(); check("sweep", exp);
            n_cmp++;
            assert (segments[7] === 1'b1)
            else begin
               n_err++;
               $error("FAIL sweep_dp: observed=%b expected=1", segments[7]);
            end
         end
      end

      // Reset in the middle of operation
      btn = 2'b10; sw[2] = 4'd15;
      tick(); check("mid_pre", 8'h8E);
      rst = 1'b1;
      tick(); check("mid_rst", 8'hFF);
      rst = 1'b0;
      tick(); check("mid_resume", 8'h8E);

      // Output changes only on a clock edge
      btn = 2'b00; sw[0] = 4'd1;
      tick(); check("lat_pre", 8'hF9);
      sw[3] = 4'd2; btn = 2'b11;
      #2; check("lat_hold", 8'hF9);
      tick(); check("lat_post", 8'hA4);

      // Randomized traffic with occasional reset
      for (int n = 0; n < 300; n++) begin
         rst = ($urandom_range(0, 15) == 0);
         btn = 2'($urandom_range(0, 3));
         for (int i = 0; i < 4; i++) sw[i] = 4'($urandom_range(0, 15));
         exp = model_next();
         tick(); check("random", exp);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/deco_7seg_with_mux_reg.md
Name: deco_7seg_with_mux_reg

Overview:
- Selects one of four 4-bit switch nibbles with a 2-bit button code.
- Decodes the selected nibble as a hexadecimal digit (0-F) into 7-segment plus decimal-point drive.
- Registers the result on the system clock.
- Sits between the board switch/button inputs and a single common-anode 7-segment digit.

Parameters:
- SEG_ACTIVE_LOW, 1, 1 = segment lit by driving 0 (common anode); 0 = inverts all 8 output bits, including reset value.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- sw_1_4  input  4  nibble 0, selected when btn=2'b00
- sw_5_8  input  4  nibble 1, selected when btn=2'b01
- sw_9_12  input  4  nibble 2, selected when btn=2'b10
- sw_13_16  input  4  nibble 3, selected when btn=2'b11
- btn  input  2  select code
- segments  output  8  {dp,g,f,e,d,c,b,a}; bit0=a … bit6=g, bit7=dp

Behaviour:
- Reset: if rst=1 at a rising clk edge, segments <= 8'hFF, all dark (8'h00 when SEG_ACTIVE_LOW=0). Reset has priority over everything else and is honoured mid-operation.
- Normal operation: each rising edge with rst=0 samples btn and all four nibbles combinationally, muxes, decodes and loads segments. Latency is exactly 1 clock from an input change to output. There is no handshake.
- Mux: purely combinational on the current btn. All four codes are valid, so there is no default/illegal case.
- Decimal point (bit7) is always off: 1 in active-low.
- Decode table, active-low hex, value -> segments:
  - 0->C0, 1->F9, 2->A4, 3->B0
  - 4->99, 5->92, 6->82, 7->F8
  - 8->80, 9->90, A->88, b->83
  - C->C6, d->A1, E->86, F->8E
- Letters b and d are lowercase glyphs; A, C, E, F are uppercase.
- Non-selected nibbles have no effect on the output.
- Simultaneous change of btn and the selected nibble: the output reflects both after the next edge.
- No X propagation is permitted after reset: the output register is always loaded from fully defined logic.

Decomposition:
- Shared package deco_7seg_pkg:
  - seg_t typedef (logic [7:0])
  - 16-entry localparam array of active-low hex patterns
  - SEG_BLANK = 8'hFF
- Sub-module hex_to_7seg: combinational 4-bit to 8-bit decoder using the package table, with the SEG_ACTIVE_LOW inversion applied there.
- The top level holds the 4:1 nibble mux and the output register.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs -> segments=8'hFF. Release rst with btn=00, sw_1_4=0 -> segments=8'hC0 one edge later.
- Select 0: btn=00, sw_1_4=10 -> segments=8'h88 ('A') after 1 edge; changing only sw_5_8/sw_9_12/sw_13_16 leaves the output at 8'h88.
- Select 1: btn=01, sw_5_8=7 -> 8'hF8. Select 2: btn=10, sw_9_12=15 -> 8'h8E. Select 3: btn=11, sw_13_16=2 -> 8'hA4.
- Full table sweep: for each btn, drive the selected nibble 0..15 -> the 16 patterns above, checked one cycle after each drive; dp bit always 1.
- Mid-operation reset: while showing 8'h8E, assert rst for one edge -> 8'hFF on that edge; resume 1 edge after deassertion with the current selection.
- Latency check: change btn 00->11 between edges -> segments changes only on the next rising edge, never combinationally.
